// File: rtl/blackjack_pkg.sv
// Shared definitions for the blackjack datapath: card ranks, rank-to-score
// mapping, card-shoe FSM states and the LFSR constants.
package blackjack_pkg;

  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  localparam int NUM_RANKS = 13;

  localparam logic [3:0] RANK_ACE   = 4'd1;
  localparam logic [3:0] RANK_TWO   = 4'd2;
  localparam logic [3:0] RANK_THREE = 4'd3;
  localparam logic [3:0] RANK_FOUR  = 4'd4;
  localparam logic [3:0] RANK_FIVE  = 4'd5;
  localparam logic [3:0] RANK_SIX   = 4'd6;
  localparam logic [3:0] RANK_SEVEN = 4'd7;
  localparam logic [3:0] RANK_EIGHT = 4'd8;
  localparam logic [3:0] RANK_NINE  = 4'd9;
  localparam logic [3:0] RANK_TEN   = 4'd10;
  localparam logic [3:0] RANK_JACK  = 4'd11;
  localparam logic [3:0] RANK_QUEEN = 4'd12;
  localparam logic [3:0] RANK_KING  = 4'd13;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SEARCH = 1'b1
  } shoe_state_e;

  // Picture cards score like a ten; rank 0 (no card yet) scores 0.
  function automatic logic [3:0] rank_to_value(input logic [3:0] rank);
    logic [3:0] value;
    value = (rank >= RANK_TEN) ? 4'd10 : rank;
    return value;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; loaded with SEED only by reset.
module lfsr16
  import blackjack_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1,
  parameter logic [LFSR_W-1:0] TAPS = LFSR_TAPS
) (
  input  logic              clock,
  input  logic              reset,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] state_d;

  always_comb begin
    state_d = state_q >> 1;
    if (state_q[0]) begin
      state_d = (state_q >> 1) ^ TAPS;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign q = state_q;

endmodule

// File: rtl/card_shoe.sv
// Shoe of NUM_DECKS decks kept as per-rank counters; deals one pseudo-random
// card per request without replacement over a req/ack handshake.
module card_shoe
  import blackjack_pkg::*;
#(
  parameter int                NUM_DECKS = 1,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  req,
  input  logic                                  shuffle,
  output logic                                  ack,
  output logic [3:0]                            card_rank,
  output logic [3:0]                            card_value,
  output logic                                  busy,
  output logic                                  empty,
  output logic [$clog2(52*NUM_DECKS+1)-1:0]     cards_left
);

  localparam int CL_W  = $clog2(52*NUM_DECKS+1);
  localparam int CNT_W = $clog2(4*NUM_DECKS+1);
  localparam logic [CL_W-1:0]  FULL_SHOE = CL_W'(52*NUM_DECKS);
  localparam logic [CNT_W-1:0] FULL_RANK = CNT_W'(4*NUM_DECKS);

  shoe_state_e       state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic              req_q, req_d;
  logic              ack_q, ack_d;
  logic [3:0]        rank_q, rank_d;
  logic [3:0]        value_q, value_d;
  logic [CL_W-1:0]   cards_left_q, cards_left_d;
  logic              empty_q, empty_d;
  logic              take;
  logic [15:0]       avail;
  logic [LFSR_W-1:0] lfsr_val;
  logic              unused_lfsr;

  lfsr16 #(
    .SEED (SEED),
    .TAPS (LFSR_TAPS)
  ) u_lfsr (
    .clock (clock),
    .reset (reset),
    .q     (lfsr_val)
  );

  assign unused_lfsr = ^lfsr_val[LFSR_W-1:4];

  // 13..15 fold onto A/2/3; the slight bias toward low ranks is accepted.
  function automatic logic [3:0] fold_idx(input logic [3:0] raw);
    logic [3:0] folded;
    folded = (raw >= 4'd13) ? (raw - 4'd13) : raw;
    return folded;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RANKS; gi++) begin : g_rank
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (shuffle) begin
          cnt_d = FULL_RANK;
        end else if (take && (idx_q == 4'(gi))) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          cnt_q <= FULL_RANK;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign avail[gi] = |cnt_q;
    end
  endgenerate

  assign avail[15:NUM_RANKS] = '0;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    // A request is only captured while idle, so one raised during SEARCH
    // cannot start a second deal right after the ack.
    req_d        = req && (state_q == ST_IDLE) && !shuffle;
    ack_d        = 1'b0;
    rank_d       = rank_q;
    value_d      = value_q;
    cards_left_d = cards_left_q;
    empty_d      = empty_q;
    take         = 1'b0;

    if (shuffle) begin
      state_d      = ST_IDLE;
      cards_left_d = FULL_SHOE;
      empty_d      = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_q && !empty_q) begin
            idx_d   = fold_idx(lfsr_val[3:0]);
            state_d = ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          if (avail[idx_q]) begin
            take         = 1'b1;
            rank_d       = idx_q + 4'd1;
            value_d      = rank_to_value(idx_q + 4'd1);
            ack_d        = 1'b1;
            cards_left_d = cards_left_q - CL_W'(1);
            empty_d      = (cards_left_q == CL_W'(1));
            state_d      = ST_IDLE;
          end else begin
            // Shoe was non-empty on entry, so this walk ends within 13 steps.
            idx_d = (idx_q == 4'd12) ? 4'd0 : (idx_q + 4'd1);
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= 4'd0;
      req_q        <= 1'b0;
      ack_q        <= 1'b0;
      rank_q       <= 4'd0;
      value_q      <= 4'd0;
      cards_left_q <= FULL_SHOE;
      empty_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      req_q        <= req_d;
      ack_q        <= ack_d;
      rank_q       <= rank_d;
      value_q      <= value_d;
      cards_left_q <= cards_left_d;
      empty_q      <= empty_d;
    end
  end

  assign ack        = ack_q;
  assign card_rank  = rank_q;
  assign card_value = value_q;
  assign busy       = (state_q == ST_SEARCH);
  assign empty      = empty_q;
  assign cards_left = cards_left_q;

endmodule

// File: tb/tb_card_shoe.sv
// Scoreboard bench for card_shoe: single-deck and double-deck instances.
module tb_card_shoe;

  logic       clock;
  logic       reset1, req1, shuffle1;
  logic       ack1, busy1, empty1;
  logic [3:0] rank1, value1;
  logic [5:0] cl1;
  logic       reset2, req2, shuffle2;
  logic       ack2, busy2, empty2;
  logic [3:0] rank2, value2;
  logic [6:0] cl2;

  int checks   = 0;
  int failures = 0;
  int q1[$];
  int q2[$];
  int tally1[16];
  int tally2[16];
  int sum1, sum2;
  int last_rank1;
  int first_rank1;
  logic prev_ack1, prev_ack2;

  card_shoe #(.NUM_DECKS(1), .SEED(16'hACE1)) dut1 (
    .clock(clock), .reset(reset1), .req(req1), .shuffle(shuffle1),
    .ack(ack1), .card_rank(rank1), .card_value(value1), .busy(busy1),
    .empty(empty1), .cards_left(cl1)
  );

  card_shoe #(.NUM_DECKS(2), .SEED(16'hACE1)) dut2 (
    .clock(clock), .reset(reset2), .req(req2), .shuffle(shuffle2),
    .ack(ack2), .card_rank(rank2), .card_value(value2), .busy(busy2),
    .empty(empty2), .cards_left(cl2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_value(input int r);
    return (r >= 10) ? 10 : r;
  endfunction

  function automatic logic get_ack(input int d);
    return (d == 1) ? ack1 : ack2;
  endfunction

  task automatic set_req(input int d, input logic v);
    if (d == 1) req1 = v;
    else        req2 = v;
  endtask

  // Issue one request and check ack latency; the monitor checks the card.
  task automatic deal(input int d, input int exp_left);
    int n;
    bit got;
    int dummy;
    if (d == 1) q1.push_back(exp_left);
    else        q2.push_back(exp_left);
    @(negedge clock);
    set_req(d, 1'b1);
    @(posedge clock);
    #1 set_req(d, 1'b0);
    n = 0;
    got = 0;
    while (!got && n < 20) begin
      @(posedge clock);
      #1;
      n++;
      if (get_ack(d)) got = 1;
    end
    checks++;
    if (!got || n < 2 || n > 14) begin
      failures++;
      $display("FAIL latency dut%0d: got %0d cycles (acked=%0d) expected 2..14", d, n, got);
      if (!got) begin
        if (d == 1) dummy = q1.pop_back();
        else        dummy = q2.pop_back();
      end
    end
  endtask

  task automatic count_acks1(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock);
      #1;
      if (ack1) n++;
    end
  endtask

  task automatic wait_mon();
    @(negedge clock);
    #1;
  endtask

  task automatic release1();
    @(negedge clock);
    reset1 = 1'b1;
  endtask

  task automatic pulse_shuffle1();
    @(negedge clock);
    shuffle1 = 1'b1;
    @(negedge clock);
    shuffle1 = 1'b0;
  endtask

  always @(negedge clock) begin
    if (ack1) begin
      chk("dut1_ack_width", int'(prev_ack1), 0);
      if (q1.size() == 0) begin
        chk("dut1_unexpected_ack", q1.size(), 1);
      end else begin
        int e;
        e = q1.pop_front();
        $display("deal dut1 rank=%0d value=%0d left=%0d empty=%0d", rank1, value1, cl1, empty1);
        chk("dut1_cards_left", int'(cl1), e);
        chk("dut1_empty", int'(empty1), int'(e == 0));
        chk("dut1_rank_valid", int'(rank1 >= 4'd1 && rank1 <= 4'd13), 1);
        chk("dut1_value", int'(value1), exp_value(int'(rank1)));
        tally1[rank1] = tally1[rank1] + 1;
        sum1 = sum1 + int'(value1);
        last_rank1 = int'(rank1);
      end
    end
    prev_ack1 = ack1;
  end

  always @(negedge clock) begin
    if (ack2) begin
      chk("dut2_ack_width", int'(prev_ack2), 0);
      if (q2.size() == 0) begin
        chk("dut2_unexpected_ack", q2.size(), 1);
      end else begin
        int e;
        e = q2.pop_front();
        $display("deal dut2 rank=%0d value=%0d left=%0d empty=%0d", rank2, value2, cl2, empty2);
        chk("dut2_cards_left", int'(cl2), e);
        chk("dut2_empty", int'(empty2), int'(e == 0));
        chk("dut2_value", int'(value2), exp_value(int'(rank2)));
        tally2[rank2] = tally2[rank2] + 1;
        sum2 = sum2 + int'(value2);
      end
    end
    prev_ack2 = ack2;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset1 = 1'b0; req1 = 1'b0; shuffle1 = 1'b0;
    reset2 = 1'b0; req2 = 1'b0; shuffle2 = 1'b0;
    prev_ack1 = 1'b0; prev_ack2 = 1'b0;
    sum1 = 0; sum2 = 0; last_rank1 = 0; first_rank1 = -1;
    for (int i = 0; i < 16; i++) begin tally1[i] = 0; tally2[i] = 0; end

    // Reset values
    repeat (3) @(posedge clock);
    release1();
    chk("rst_ack", int'(ack1), 0);
    chk("rst_rank", int'(rank1), 0);
    chk("rst_value", int'(value1), 0);
    chk("rst_busy", int'(busy1), 0);
    chk("rst_empty", int'(empty1), 0);
    chk("rst_cards_left", int'(cl1), 52);

    // Single deal from power-up
    deal(1, 51);
    wait_mon();
    first_rank1 = last_rank1;
    chk("single_cards_left", int'(cl1), 51);

    // Full drain of a fresh shoe
    pulse_shuffle1();
    chk("shuffle_restore_left", int'(cl1), 52);
    chk("shuffle_restore_busy", int'(busy1), 0);
    for (int i = 0; i < 16; i++) tally1[i] = 0;
    sum1 = 0;
    for (int i = 0; i < 52; i++) deal(1, 51 - i);
    wait_mon();
    for (int r = 1; r <= 13; r++) chk($sformatf("drain_rank%0d_count", r), tally1[r], 4);
    chk("drain_value_sum", sum1, 340);
    chk("drain_empty", int'(empty1), 1);
    chk("drain_cards_left", int'(cl1), 0);

    // Request on an empty shoe is ignored
    @(negedge clock); req1 = 1'b1;
    @(posedge clock); #1 req1 = 1'b0;
    count_acks1(20, n);
    chk("empty_req_no_ack", n, 0);
    chk("empty_req_busy", int'(busy1), 0);

    // Shuffle one cycle after req aborts the deal
    pulse_shuffle1();
    deal(1, 51);
    wait_mon();
    @(negedge clock); req1 = 1'b1;
    @(negedge clock); req1 = 1'b0; shuffle1 = 1'b1;
    @(negedge clock); shuffle1 = 1'b0;
    chk("abort1_busy", int'(busy1), 0);
    count_acks1(20, n);
    chk("abort1_no_ack", n, 0);
    chk("abort1_cards_left", int'(cl1), 52);

    // Shuffle while SEARCH is in progress
    deal(1, 51);
    wait_mon();
    @(negedge clock); req1 = 1'b1;
    @(posedge clock); #1 req1 = 1'b0;
    n = 0;
    while (!busy1 && n < 5) begin @(posedge clock); #1; n++; end
    chk("abort2_saw_busy", int'(busy1), 1);
    shuffle1 = 1'b1;
    @(posedge clock); #1 shuffle1 = 1'b0;
    chk("abort2_busy", int'(busy1), 0);
    count_acks1(20, n);
    chk("abort2_no_ack", n, 0);
    chk("abort2_cards_left", int'(cl1), 52);

    // Shuffle and req in the same cycle: req dropped
    @(negedge clock); req1 = 1'b1; shuffle1 = 1'b1;
    @(negedge clock); req1 = 1'b0; shuffle1 = 1'b0;
    count_acks1(20, n);
    chk("same_cycle_no_ack", n, 0);
    chk("same_cycle_busy", int'(busy1), 0);

    // Reset asserted mid-SEARCH
    deal(1, 51);
    wait_mon();
    @(negedge clock); req1 = 1'b1;
    @(posedge clock); #1 req1 = 1'b0;
    n = 0;
    while (!busy1 && n < 5) begin @(posedge clock); #1; n++; end
    chk("midrst_saw_busy", int'(busy1), 1);
    reset1 = 1'b0;
    #1;
    chk("midrst_ack", int'(ack1), 0);
    chk("midrst_busy", int'(busy1), 0);
    chk("midrst_rank", int'(rank1), 0);
    chk("midrst_cards_left", int'(cl1), 52);
    repeat (3) @(posedge clock);
    release1();
    deal(1, 51);
    wait_mon();
    chk("midrst_same_first_card", last_rank1, first_rank1);
    chk("midrst_cards_left_after", int'(cl1), 51);

    // Double-deck shoe: full drain
    repeat (3) @(posedge clock);
    @(negedge clock); reset2 = 1'b1;
    chk("dd_rst_cards_left", int'(cl2), 104);
    for (int i = 0; i < 104; i++) deal(2, 103 - i);
    wait_mon();
    for (int r = 1; r <= 13; r++) chk($sformatf("dd_rank%0d_count", r), tally2[r], 8);
    chk("dd_value_sum", sum2, 680);
    chk("dd_cards_left", int'(cl2), 0);
    chk("dd_empty", int'(empty2), 1);

    repeat (2) @(negedge clock);
    chk("queue1_drained", q1.size(), 0);
    chk("queue2_drained", q2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/card_shoe.md
# card_shoe

Parametrised card source for the blackjack datapath, replacing the fixed card memory. It holds a shoe of `NUM_DECKS` standard 52-card decks as per-rank counters and deals one pseudo-random card per request, without replacement. Results come back over a req/ack handshake. It sits between the game state machine (requester) and the score/display logic (consumer of `card_value`).

## Interface
- `NUM_DECKS`, default 1: decks in the shoe, legal 1..8.
- `SEED`, default 16'hACE1: LFSR reset value; must be nonzero.
- `clock` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-low.
- `req` input, 1 bit: deal request, sampled in IDLE only.
- `shuffle` input, 1 bit: restore the full shoe; wins over everything except reset.
- `ack` output, 1 bit: one-cycle pulse; card outputs valid.
- `card_rank` output, 4 bits: 1=A, 2..10, 11=J, 12=Q, 13=K.
- `card_value` output, 4 bits: A=1, 2..10 face value, J/Q/K=10.
- `busy` output, 1 bit: high while in SEARCH.
- `empty` output, 1 bit: `cards_left == 0`.
- `cards_left` output, `$clog2(52*NUM_DECKS+1)` bits: cards remaining.

## Operation
- Storage:
  - 13 rank counters, each `$clog2(4*NUM_DECKS+1)` bits, loaded to `4*NUM_DECKS`.
  - `cards_left` is loaded to `52*NUM_DECKS`.
- LFSR:
  - 16-bit Galois, taps 16'hB400.
  - Free-running: advances every cycle in every state.
  - Loaded with `SEED` on reset only; `shuffle` does not reseed.
- FSM states: IDLE, SEARCH.
- IDLE:
  - `req=1` and `empty=0`: latch `idx = lfsr[3:0]`, folding values 13..15 to 0..2 (bias on A/2/3 is accepted). Go to SEARCH.
  - `req=1` and `empty=1`: ignored. No ack, stay in IDLE.
- SEARCH, one rank checked per cycle:
  - `count[idx] != 0`:
    - At the next edge, decrement `count[idx]` and `cards_left`.
    - Register `card_rank = idx+1` and `card_value` from the mapping.
    - Pulse `ack`, return to IDLE.
  - `count[idx] == 0`: `idx = (idx==12) ? 0 : idx+1`, stay in SEARCH.
  - Termination: `cards_left > 0` was guaranteed on entry, so SEARCH ends within 13 cycles.
- `shuffle=1`, any state:
  - At the next edge, reload all counters and `cards_left`, and force IDLE.
  - An in-flight request is aborted and never acked.
  - `req` in the same cycle is dropped.
- `card_rank`/`card_value` hold the last dealt card until the next ack.
- `req` held high: one deal per IDLE visit, so back-to-back deals are spaced by at least 2 cycles.

## Timing
- Reset values:
  - `ack=0`, `card_rank=0`, `card_value=0`, `busy=0`, `empty=0`.
  - `cards_left=52*NUM_DECKS`, counters full, LFSR=`SEED`, state IDLE.
- Latency: if `req` is sampled at edge k, `ack` is high after edge k+2 (best) through k+14 (worst).
- `busy` is high from edge k+1 until the edge that raises `ack`. It is low in the `ack` cycle.
- Registered updates:
  - `cards_left` and `empty` update on the same edge as `ack`.
  - On the 52·N-th deal, `empty` rises together with that `ack`.
- Reset asserted mid-SEARCH: outputs return to reset values asynchronously, with no ack afterwards.
- All outputs are registered; there are no combinational paths from inputs.

## Structure
- `blackjack_pkg`:
  - Rank constants (RANK_ACE..RANK_KING).
  - `rank_to_value` function.
  - FSM state enum.
  - LFSR width and tap constant.
- Sub-module `lfsr16`: parameters `SEED`, `TAPS`; ports `clock`, `reset`, `q[15:0]`.
- The rank counter array and FSM stay in `card_shoe`.

## Test plan
- Reset value check: hold `reset=0` for 3 cycles, then release. All outputs equal their reset values and `cards_left=52`.
- Single deal (`NUM_DECKS=1`, `SEED=16'hACE1`): pulse `req` → `ack` within 2..14 cycles, exactly one cycle wide, `cards_left=51`, `card_value` consistent with `card_rank`.
- Full drain: issue 52 requests.
  - Each rank is dealt exactly 4 times, and the sum of `card_value` is 340.
  - `empty` rises with the 52nd ack.
  - A 53rd `req` produces no `ack` within 20 cycles.
- Shuffle abort: `req`, then `shuffle` one cycle later. No `ack`, `cards_left=52`, `busy=0` next cycle. `shuffle` and `req` in the same cycle: no `ack`.
- `NUM_DECKS=2`: drain 104 cards. Each rank is dealt 8 times, and `cards_left` is 7 bits wide and reaches 0.
- Reset mid-SEARCH: deassert `reset` while `busy=1`. There is no stray `ack`, and the next deal behaves as after power-up with a full shoe.
